// File: rtl/lamp_pkg.sv
// Shared types and constants for the lamp shift driver and its bench.
package lamp_pkg;

  localparam int unsigned LAMP_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StShiftLo = 2'd1,
    StShiftHi = 2'd2,
    StLatch   = 2'd3
  } lamp_state_e;

  // Cycles busy stays high for one frame: two phases per bit plus the latch pulse.
  function automatic int unsigned frame_cycles(input int unsigned width,
                                               input int unsigned clk_div);
    return width * 2 * clk_div + clk_div;
  endfunction

endpackage

// File: rtl/lamp_phase_tick.sv
// Phase timer: counts CLK_DIV cycles and pulses tick_o on the last one.
module lamp_phase_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [7:0] Load = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q - 8'd1;
    // Reload on clear and on wrap so consecutive phases run back to back.
    if (clr_i || (div_cnt_q == 8'd0)) begin
      div_cnt_d = Load;
    end
  end

  assign tick_o = !clr_i && (div_cnt_q == 8'd0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_cnt_q <= Load;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/lamp_shift_driver.sv
// Serialises the lamp vector into a 595-style latch chain whenever it changes
// or a refresh is requested; mid-frame changes coalesce into the next frame.
module lamp_shift_driver
  import lamp_pkg::*;
#(
  parameter int unsigned WIDTH     = LAMP_WIDTH,
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] lamp_in,
  input  logic             refresh,
  output logic             sclk,
  output logic             sdata,
  output logic             slatch,
  output logic             busy
);

  localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  lamp_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             slatch_q, slatch_d;
  logic             busy_q, busy_d;

  logic             tick;
  logic             phase_clr;
  logic             start;
  logic             last_bit;
  logic [WIDTH-1:0] shreg_next;

  function automatic logic lead_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  assign phase_clr  = (state_q == StIdle);
  assign start      = (state_q == StIdle) && ((lamp_in != shadow_q) || refresh || pending_q);
  assign last_bit   = (bit_cnt_q == LastBit);
  assign shreg_next = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

  lamp_phase_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_phase_tick (
    .clk_i  (clk),
    .reset_i(reset),
    .clr_i  (phase_clr),
    .tick_o (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StShiftLo;
      StShiftLo: if (tick)  state_d = StShiftHi;
      StShiftHi: if (tick)  state_d = last_bit ? StLatch : StShiftLo;
      StLatch:   if (tick)  state_d = StIdle;
      default:              state_d = StIdle;
    endcase
  end

  always_comb begin
    shreg_d   = shreg_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    slatch_d  = slatch_q;
    busy_d    = busy_q;

    // A refresh while busy is remembered so exactly one extra frame follows.
    if (start) begin
      pending_d = 1'b0;
    end else if (refresh && (state_q != StIdle)) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shreg_d   = lamp_in;
          shadow_d  = lamp_in;
          bit_cnt_d = '0;
          sdata_d   = lead_bit(lamp_in);
          sclk_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end
      StShiftLo: begin
        if (tick) sclk_d = 1'b1;
      end
      StShiftHi: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (last_bit) begin
            sdata_d  = 1'b0;
            slatch_d = 1'b1;
          end else begin
            shreg_d   = shreg_next;
            sdata_d   = lead_bit(shreg_next);
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      StLatch: begin
        if (tick) begin
          slatch_d = 1'b0;
          busy_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q   <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b1;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      slatch_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      slatch_q  <= slatch_d;
      busy_q    <= busy_d;
    end
  end

  assign sclk   = sclk_q;
  assign sdata  = sdata_q;
  assign slatch = slatch_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_lamp_shift_driver.sv
// Bench for lamp_shift_driver: a CLK_DIV=4 instance and a CLK_DIV=1 instance,
// frames decoded from the serial lines and compared against a scoreboard.
module tb_lamp_shift_driver;
  import lamp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst1;
  logic [15:0] lamp0, lamp1;
  logic        ref0, ref1;
  logic        sclk0, sdata0, slatch0, busy0;
  logic        sclk1, sdata1, slatch1, busy1;

  lamp_shift_driver #(.WIDTH(16), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .reset(rst), .lamp_in(lamp0), .refresh(ref0),
    .sclk(sclk0), .sdata(sdata0), .slatch(slatch0), .busy(busy0)
  );

  lamp_shift_driver #(.WIDTH(16), .CLK_DIV(1), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(rst1), .lamp_in(lamp1), .refresh(ref1),
    .sclk(sclk1), .sdata(sdata1), .slatch(slatch1), .busy(busy1)
  );

  wire [1:0] sclk_w   = {sclk1, sclk0};
  wire [1:0] sdata_w  = {sdata1, sdata0};
  wire [1:0] slatch_w = {slatch1, slatch0};
  wire [1:0] busy_w   = {busy1, busy0};
  wire [1:0] rst_w    = {rst1, rst};

  typedef struct { int d; logic [15:0] v; } exp_t;
  typedef struct { logic [15:0] lamp; bit refresh; int nframes; } vec_t;

  exp_t sb_q[$];
  vec_t vecs[5];

  int checks = 0;
  int errors = 0;
  int divs[2] = '{4, 1};
  int nbits[2], bcnt[2], lcnt[2], gcnt[2], last_gap[2], frames[2];
  logic [15:0] cap[2];
  logic psclk[2], pslatch[2], pbusy[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int d, input logic [15:0] v);
    exp_t e;
    e.d = d;
    e.v = v;
    sb_q.push_back(e);
  endtask

  task automatic wait_quiet(input int d);
    int quiet = 0;
    int n = 0;
    while (quiet < 8 && n < 2000) begin
      @(negedge clk);
      n++;
      if (busy_w[d]) quiet = 0;
      else quiet++;
    end
    chk("settle", quiet >= 8, 1);
  endtask

  task automatic wait_busy(input int d);
    int n = 0;
    while (!busy_w[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busy_seen", busy_w[d], 1);
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1; rst1 = 1'b1;
    lamp0 = '0; lamp1 = '0; ref0 = 1'b0; ref1 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      nbits[d] = 0; bcnt[d] = 0; lcnt[d] = 0; gcnt[d] = 0; last_gap[d] = 0; frames[d] = 0;
      cap[d] = '0; psclk[d] = 1'b0; pslatch[d] = 1'b0; pbusy[d] = 1'b0;
    end
    vecs[0] = '{16'h003F, 1'b0, 1};  // change -> one frame
    vecs[1] = '{16'h003F, 1'b0, 0};  // unchanged -> nothing
    vecs[2] = '{16'h003F, 1'b1, 1};  // refresh resends
    vecs[3] = '{16'h8001, 1'b1, 1};  // change and refresh together -> one frame
    vecs[4] = '{16'h5AA5, 1'b0, 1};

    fork
      forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          if (rst_w[d]) begin
            nbits[d] = 0; bcnt[d] = 0; lcnt[d] = 0; gcnt[d] = 0;
            psclk[d] = 1'b0; pslatch[d] = 1'b0; pbusy[d] = 1'b0;
          end else begin
            if (sclk_w[d] && !psclk[d]) begin
              cap[d] = {cap[d][14:0], sdata_w[d]};
              nbits[d]++;
            end
            if (slatch_w[d] && !pslatch[d]) begin
              frames[d]++;
              chk("sb_nonempty", sb_q.size() != 0, 1);
              if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("frame_dut", d, e.d);
                chk("frame_data", cap[d], e.v);
              end
              chk("frame_bits", nbits[d], 16);
              nbits[d] = 0;
            end
            if (slatch_w[d]) lcnt[d]++;
            if (!slatch_w[d] && pslatch[d]) begin
              chk("latch_len", lcnt[d], divs[d]);
              lcnt[d] = 0;
            end
            if (busy_w[d]) bcnt[d]++;
            else gcnt[d]++;
            if (busy_w[d] && !pbusy[d]) begin
              last_gap[d] = gcnt[d];
              gcnt[d] = 0;
            end
            if (!busy_w[d] && pbusy[d]) begin
              chk("busy_len", bcnt[d], frame_cycles(16, divs[d]));
              bcnt[d] = 0;
            end
            psclk[d] = sclk_w[d]; pslatch[d] = slatch_w[d]; pbusy[d] = busy_w[d];
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_outs0", {sclk0, sdata0, slatch0, busy0}, 4'b0000);
    chk("reset_outs1", {sclk1, sdata1, slatch1, busy1}, 4'b0000);

    // Unconditional first frame after reset.
    push_exp(0, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("start_latency", busy0, 1);
    wait_quiet(0);
    chk("frames_after_reset", frames[0], 1);

    for (int i = 0; i < 5; i++) begin
      base = frames[0];
      if (vecs[i].nframes != 0) push_exp(0, vecs[i].lamp);
      lamp0 = vecs[i].lamp;
      ref0 = vecs[i].refresh;
      @(negedge clk);
      ref0 = 1'b0;
      wait_quiet(0);
      chk("vec_frames", frames[0] - base, vecs[i].nframes);
      chk("vec_sb_empty", sb_q.size(), 0);
    end

    // Coalescing: 0003 is overtaken by 0007 before the first frame ends.
    base = frames[0];
    push_exp(0, 16'h0001);
    push_exp(0, 16'h0007);
    lamp0 = 16'h0001;
    wait_busy(0);
    repeat (10) @(negedge clk);
    lamp0 = 16'h0003;
    repeat (10) @(negedge clk);
    lamp0 = 16'h0007;
    wait_quiet(0);
    chk("coalesce_frames", frames[0] - base, 2);
    chk("coalesce_gap", last_gap[0], 1);

    // Several refreshes in one frame yield a single extra frame.
    base = frames[0];
    push_exp(0, 16'hFFFF);
    push_exp(0, 16'hFFFF);
    lamp0 = 16'hFFFF;
    wait_busy(0);
    for (int k = 0; k < 3; k++) begin
      repeat (20) @(negedge clk);
      ref0 = 1'b1;
      @(negedge clk);
      ref0 = 1'b0;
    end
    wait_quiet(0);
    chk("refresh_frames", frames[0] - base, 2);
    chk("refresh_sb_empty", sb_q.size(), 0);

    // Value returns to the sent one before the frame ends: nothing extra.
    base = frames[0];
    push_exp(0, 16'h1234);
    lamp0 = 16'h1234;
    wait_busy(0);
    repeat (10) @(negedge clk);
    lamp0 = 16'h4321;
    repeat (10) @(negedge clk);
    lamp0 = 16'h1234;
    wait_quiet(0);
    chk("return_frames", frames[0] - base, 1);

    // Reset mid-frame at bit 7, then a full resend.
    base = frames[0];
    lamp0 = 16'hC3C3;
    n = 0;
    while (nbits[0] < 7 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reached_bit7", nbits[0], 7);
    chk("busy_before_reset", busy0, 1);
    rst = 1'b1;
    #1;
    chk("async_reset_outs", {sclk0, sdata0, slatch0, busy0}, 4'b0000);
    repeat (3) @(negedge clk);
    push_exp(0, 16'hC3C3);
    rst = 1'b0;
    wait_quiet(0);
    chk("post_reset_frames", frames[0] - base, 1);
    chk("post_reset_sb_empty", sb_q.size(), 0);

    // CLK_DIV=1 instance.
    push_exp(1, 16'hA5A5);
    lamp1 = 16'hA5A5;
    rst1 = 1'b0;
    wait_quiet(1);
    chk("div1_frames", frames[1], 1);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
